// File: rtl/spi_ctrl_pkg.sv
// Shared constants for the SPI frame controllers: opcodes, error codes and
// the write-controller state encoding.
package spi_ctrl_pkg;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_NOP   = 8'h00;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_OPCODE = 2'd1;
    localparam logic [1:0] ERR_SHORT  = 2'd2;
    localparam logic [1:0] ERR_OVR    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_DRAIN,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module cdc_sync_bit #(
    parameter int   STAGES  = 3,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_wr_ctrl.sv
// Parses CS-bounded SPI frames (cmd, addr, len, data...) into register-bus
// writes with auto-incrementing address, backpressure and error reporting.
module spi_wr_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_RX_Byte,
    input  logic              i_RX_Ready,
    input  logic              i_CS_n,
    output logic              o_Wr_En,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [7:0]        o_Wr_Data,
    input  logic              i_Wr_Ready,
    output logic              o_Busy,
    output logic              o_Frame_Done,
    output logic              o_Err,
    output logic [1:0]        o_Err_Code
);

    logic cs_sync;
    logic cs_prev;
    logic cs_fall;
    logic cs_rise;

    state_t            state, state_n;
    logic [7:0]        addr_q, addr_n;
    logic [7:0]        cnt_q, cnt_n;
    logic              wr_en_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [7:0]        wr_data_n;
    logic              busy_n;
    logic              done_n;
    logic              err_n;
    logic [1:0]        code_n;
    logic              accept;

    cdc_sync_bit #(
        .STAGES (3),
        .RST_VAL(1'b1)
    ) u_cs_sync (
        .clk(clk),
        .rst(rst),
        .d  (i_CS_n),
        .q  (cs_sync)
    );

    assign cs_fall = cs_prev & ~cs_sync;
    assign cs_rise = ~cs_prev & cs_sync;
    assign accept  = o_Wr_En & i_Wr_Ready;

    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        cnt_n     = cnt_q;
        wr_en_n   = o_Wr_En;
        wr_addr_n = o_Wr_Addr;
        wr_data_n = o_Wr_Data;
        busy_n    = o_Busy;
        done_n    = 1'b0;
        err_n     = o_Err;
        code_n    = o_Err_Code;

        if (accept) wr_en_n = 1'b0;
        if (o_Frame_Done) busy_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_n = ST_CMD;
                    busy_n  = 1'b1;
                    err_n   = 1'b0;
                    code_n  = ERR_NONE;
                end
            end
            ST_CMD: begin
                if (i_RX_Ready) begin
                    if (i_RX_Byte == OP_WRITE) begin
                        state_n = ST_ADDR;
                    end else begin
                        state_n = ST_DRAIN;
                        if (i_RX_Byte != OP_NOP && code_n == ERR_NONE) begin
                            err_n  = 1'b1;
                            code_n = ERR_OPCODE;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (i_RX_Ready) begin
                    addr_n  = i_RX_Byte;
                    state_n = ST_LEN;
                end
            end
            ST_LEN: begin
                if (i_RX_Ready) begin
                    cnt_n   = i_RX_Byte;
                    state_n = (i_RX_Byte == 8'd0) ? ST_DRAIN : ST_DATA;
                end
            end
            ST_DATA: begin
                if (i_RX_Ready) begin
                    cnt_n = cnt_q - 8'd1;
                    // A byte landing while the previous write is still stalled is dropped
                    if (o_Wr_En && !i_Wr_Ready) begin
                        if (code_n == ERR_NONE) begin
                            err_n  = 1'b1;
                            code_n = ERR_OVR;
                        end
                    end else begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = ADDR_W'(addr_q);
                        wr_data_n = i_RX_Byte;
                        addr_n    = addr_q + 8'd1;
                    end
                    if (cnt_q == 8'd1) state_n = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                if (accept) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: ;
        endcase

        // CS rise is applied after any same-cycle byte has been consumed
        if (cs_rise && state != ST_IDLE && state != ST_FLUSH) begin
            if ((state_n inside {ST_CMD, ST_ADDR, ST_LEN} ||
                 (state_n == ST_DATA && cnt_n != 8'd0)) && code_n == ERR_NONE) begin
                err_n  = 1'b1;
                code_n = ERR_SHORT;
            end
            if (wr_en_n) begin
                state_n = ST_FLUSH;
            end else begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cs_prev      <= 1'b1;
            addr_q       <= '0;
            cnt_q        <= '0;
            o_Wr_En      <= 1'b0;
            o_Wr_Addr    <= '0;
            o_Wr_Data    <= '0;
            o_Busy       <= 1'b0;
            o_Frame_Done <= 1'b0;
            o_Err        <= 1'b0;
            o_Err_Code   <= ERR_NONE;
        end else begin
            state        <= state_n;
            cs_prev      <= cs_sync;
            addr_q       <= addr_n;
            cnt_q        <= cnt_n;
            o_Wr_En      <= wr_en_n;
            o_Wr_Addr    <= wr_addr_n;
            o_Wr_Data    <= wr_data_n;
            o_Busy       <= busy_n;
            o_Frame_Done <= done_n;
            o_Err        <= err_n;
            o_Err_Code   <= code_n;
        end
    end

endmodule

// File: tb/tb_spi_wr_ctrl.sv
// Directed bench for spi_wr_ctrl: frame parsing, backpressure, errors, reset.
module tb_spi_wr_ctrl;

    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic [7:0]    rx_byte;
    logic          rx_ready;
    logic          cs_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          busy;
    logic          frame_done;
    logic          err;
    logic [1:0]    err_code;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] wr_log[$];
    int          done_cnt = 0;

    spi_wr_ctrl #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_RX_Byte   (rx_byte),
        .i_RX_Ready  (rx_ready),
        .i_CS_n      (cs_n),
        .o_Wr_En     (wr_en),
        .o_Wr_Addr   (wr_addr),
        .o_Wr_Data   (wr_data),
        .i_Wr_Ready  (wr_ready),
        .o_Busy      (busy),
        .o_Frame_Done(frame_done),
        .o_Err       (err),
        .o_Err_Code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus-side observer: logs every accepted write and every frame-done pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en && wr_ready) wr_log.push_back({wr_addr, wr_data});
            if (frame_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (6) tick();
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({wr_en, wr_addr, wr_data, busy, frame_done, err, err_code} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got en=%0b a=%h d=%h busy=%0b done=%0b err=%0b code=%0d exp all zero",
                     wr_en, wr_addr, wr_data, busy, frame_done, err, err_code);
        end
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy got %0b exp 0", busy);
        end
    endtask

    task automatic test_basic_burst();
        int s = wr_log.size();
        int d = done_cnt;
        wr_ready = 1'b1;
        cs_low();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_high got %0b exp 1", busy);
        end
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'hAA);
        n_checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h10, 8'hAA}) begin
            n_fail++;
            $display("FAIL basic_latency got en=%0b a=%h d=%h exp en=1 a=10 d=aa", wr_en, wr_addr, wr_data);
        end
        send_byte(8'hBB);
        send_byte(8'hCC);
        repeat (2) tick();
        cs_high();
        n_checks++;
        if (wr_log.size() - s !== 3) begin
            n_fail++;
            $display("FAIL basic_count got %0d exp 3", wr_log.size() - s);
        end
        n_checks++;
        if (wr_log[s] !== 16'h10AA || wr_log[s+1] !== 16'h11BB || wr_log[s+2] !== 16'h12CC) begin
            n_fail++;
            $display("FAIL basic_writes got %h %h %h exp 10aa 11bb 12cc", wr_log[s], wr_log[s+1], wr_log[s+2]);
        end
        n_checks++;
        if (done_cnt - d !== 1) begin
            n_fail++;
            $display("FAIL basic_done got %0d exp 1", done_cnt - d);
        end
        n_checks++;
        if ({err, err_code, busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL basic_err got err=%0b code=%0d busy=%0b exp 0 0 0", err, err_code, busy);
        end
    endtask

    task automatic test_wrap_overlong();
        int s = wr_log.size();
        int d = done_cnt;
        wr_ready = 1'b1;
        cs_low();
        send_byte(8'h02);
        send_byte(8'hFE);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (2) tick();
        cs_high();
        n_checks++;
        if (wr_log.size() - s !== 2) begin
            n_fail++;
            $display("FAIL wrap_count got %0d exp 2", wr_log.size() - s);
        end
        n_checks++;
        if (wr_log[s] !== 16'hFE11 || wr_log[s+1] !== 16'hFF22) begin
            n_fail++;
            $display("FAIL wrap_writes got %h %h exp fe11 ff22", wr_log[s], wr_log[s+1]);
        end
        n_checks++;
        if ({err, err_code} !== 3'b0 || done_cnt - d !== 1) begin
            n_fail++;
            $display("FAIL wrap_status got err=%0b code=%0d done=%0d exp 0 0 1", err, err_code, done_cnt - d);
        end
    endtask

    task automatic test_zero_len();
        int s = wr_log.size();
        int d = done_cnt;
        wr_ready = 1'b1;
        cs_low();
        send_byte(8'h02);
        send_byte(8'h30);
        send_byte(8'h00);
        send_byte(8'h77);
        cs_high();
        n_checks++;
        if (wr_log.size() - s !== 0 || done_cnt - d !== 1 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL zero_len got writes=%0d done=%0d code=%0d exp 0 1 0",
                     wr_log.size() - s, done_cnt - d, err_code);
        end
    endtask

    task automatic test_short_backpressure();
        int s = wr_log.size();
        int d = done_cnt;
        wr_ready = 1'b1;
        cs_low();
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        wr_ready = 1'b0;
        cs_high();
        n_checks++;
        if (done_cnt - d !== 0 || wr_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL short_flush_hold got done=%0d en=%0b busy=%0b exp 0 1 1", done_cnt - d, wr_en, busy);
        end
        n_checks++;
        if ({wr_addr, wr_data} !== 16'h2102) begin
            n_fail++;
            $display("FAIL short_pending got %h exp 2102", {wr_addr, wr_data});
        end
        wr_ready = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (wr_log.size() - s !== 2 || wr_log[s] !== 16'h2001 || wr_log[s+1] !== 16'h2102) begin
            n_fail++;
            $display("FAIL short_writes got n=%0d %h %h exp 2 2001 2102", wr_log.size() - s, wr_log[s], wr_log[s+1]);
        end
        n_checks++;
        if (done_cnt - d !== 1 || err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL short_status got done=%0d err=%0b code=%0d busy=%0b exp 1 1 2 0",
                     done_cnt - d, err, err_code, busy);
        end
    endtask

    task automatic test_bad_opcode();
        int s = wr_log.size();
        int d = done_cnt;
        wr_ready = 1'b1;
        cs_low();
        send_byte(8'h7F);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        cs_high();
        n_checks++;
        if (wr_log.size() - s !== 0 || err !== 1'b1 || err_code !== 2'd1 || done_cnt - d !== 1) begin
            n_fail++;
            $display("FAIL badop got writes=%0d err=%0b code=%0d done=%0d exp 0 1 1 1",
                     wr_log.size() - s, err, err_code, done_cnt - d);
        end
        cs_low();
        n_checks++;
        if ({err, err_code} !== 3'b0) begin
            n_fail++;
            $display("FAIL err_clear got err=%0b code=%0d exp 0 0", err, err_code);
        end
        send_byte(8'h00);
        send_byte(8'h44);
        cs_high();
        n_checks++;
        if ({err, err_code} !== 3'b0 || done_cnt - d !== 2 || wr_log.size() - s !== 0) begin
            n_fail++;
            $display("FAIL nop_frame got err=%0b code=%0d done=%0d writes=%0d exp 0 0 2 0",
                     err, err_code, done_cnt - d, wr_log.size() - s);
        end
    endtask

    task automatic test_overrun();
        int s = wr_log.size();
        int d = done_cnt;
        wr_ready = 1'b0;
        cs_low();
        send_byte(8'h02);
        send_byte(8'h40);
        send_byte(8'h03);
        send_byte(8'h55);
        tick();
        send_byte(8'h66);
        tick();
        n_checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h40, 8'h55}) begin
            n_fail++;
            $display("FAIL ovr_pending got en=%0b a=%h d=%h exp 1 40 55", wr_en, wr_addr, wr_data);
        end
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'd3) begin
            n_fail++;
            $display("FAIL ovr_code got err=%0b code=%0d exp 1 3", err, err_code);
        end
        // Frame is also short, but the overrun was first and must stay latched
        cs_high();
        wr_ready = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (wr_log.size() - s !== 1 || wr_log[s] !== 16'h4055) begin
            n_fail++;
            $display("FAIL ovr_writes got n=%0d %h exp 1 4055", wr_log.size() - s, wr_log[s]);
        end
        n_checks++;
        if (err_code !== 2'd3 || done_cnt - d !== 1) begin
            n_fail++;
            $display("FAIL ovr_first_err got code=%0d done=%0d exp 3 1", err_code, done_cnt - d);
        end
    endtask

    task automatic test_reset_mid_frame();
        int s = wr_log.size();
        int d = done_cnt;
        wr_ready = 1'b0;
        cs_low();
        send_byte(8'h02);
        send_byte(8'h50);
        send_byte(8'h02);
        send_byte(8'h99);
        n_checks++;
        if (wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pending got en=%0b exp 1", wr_en);
        end
        rst  = 1'b1;
        cs_n = 1'b1;
        tick();
        n_checks++;
        if ({wr_en, wr_addr, wr_data, busy, frame_done, err, err_code} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got en=%0b a=%h d=%h busy=%0b done=%0b err=%0b code=%0d exp all zero",
                     wr_en, wr_addr, wr_data, busy, frame_done, err, err_code);
        end
        repeat (2) tick();
        rst = 1'b0;
        wr_ready = 1'b1;
        repeat (8) tick();
        n_checks++;
        if (done_cnt - d !== 0 || wr_log.size() - s !== 0) begin
            n_fail++;
            $display("FAIL rstmid_abort got done=%0d writes=%0d exp 0 0", done_cnt - d, wr_log.size() - s);
        end
        cs_low();
        send_byte(8'h02);
        send_byte(8'h60);
        send_byte(8'h01);
        send_byte(8'h5A);
        tick();
        cs_high();
        n_checks++;
        if (wr_log.size() - s !== 1 || wr_log[s] !== 16'h605A || done_cnt - d !== 1 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_recover got n=%0d w=%h done=%0d code=%0d exp 1 605a 1 0",
                     wr_log.size() - s, wr_log[s], done_cnt - d, err_code);
        end
    endtask

    initial begin
        rst      = 1'b1;
        cs_n     = 1'b1;
        rx_byte  = 8'h00;
        rx_ready = 1'b0;
        wr_ready = 1'b0;
        test_reset();
        test_basic_burst();
        test_wrap_overlong();
        test_zero_len();
        test_short_backpressure();
        test_bad_opcode();
        test_overrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
